huff_decoder: RTL and testbench

- Receive side of the chip's Huffman path; consumes the same code format the encoder produces: a 3-bit code value plus a 3-bit mask, mask ones contiguous from the LSB.
- First loads a codebook of up to NUM_SYMS (symbol, code, mask) entries.
- Then decodes a serial bitstream, one bit per cycle when valid, into 8-bit symbols.
- Sits beside huff_encoder in the chip wrapper for loopback and self-check.

---
 rtl/huff_decoder.sv | 123 ++++++++++++
 tb/tb_huff_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/huff_decoder.sv
// huff_decoder: loads a small (symbol, code, mask) codebook, then decodes a serial bitstream into symbols
module huff_decoder #(
    parameter int NUM_SYMS = 4,
    parameter int SYM_W    = 8,
    parameter int CODE_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [SYM_W-1:0]  load_sym,
    input  logic [CODE_W-1:0] load_code,
    input  logic [CODE_W-1:0] load_mask,
    input  logic              load_last,
    output logic              table_ready,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym_out,
    output logic              err
);
    localparam int CNT_W = $clog2(NUM_SYMS + 1);
    localparam int LEN_W = $clog2(CODE_W + 1);
    typedef enum logic {LOAD, DECODE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SYM_W-1:0] ent_sym_q [NUM_SYMS];
    logic [SYM_W-1:0] ent_sym_d [NUM_SYMS];
    logic [CODE_W-1:0] ent_code_q [NUM_SYMS];
    logic [CODE_W-1:0] ent_code_d [NUM_SYMS];
    logic [CODE_W-1:0] ent_mask_q [NUM_SYMS];
    logic [CODE_W-1:0] ent_mask_d [NUM_SYMS];
    logic [LEN_W-1:0] ent_len_q [NUM_SYMS];
    logic [LEN_W-1:0] ent_len_d [NUM_SYMS];
    logic [NUM_SYMS-1:0] ent_ok_q, ent_ok_d;
    logic [CODE_W-1:0] acc_q, acc_d, acc_nx;
    logic [LEN_W-1:0] n_q, n_d, n_nx;
    logic sym_valid_q, sym_valid_d, err_q, err_d;
    logic [SYM_W-1:0] sym_out_q, sym_out_d;
    logic [LEN_W-1:0] load_len;
    logic load_ok, hit;
    logic [SYM_W-1:0] hit_sym;
    always_comb begin
        load_len = '0;
        for (int j = 0; j < CODE_W; j++) load_len = load_len + LEN_W'(load_mask[j]);
        load_ok = (load_mask != '0) && ((load_mask & (load_mask + 1'b1)) == '0);
        acc_nx = {acc_q[CODE_W-2:0], bit_in};
        n_nx = n_q + 1'b1;
        hit = 1'b0;
        hit_sym = '0;
        for (int i = NUM_SYMS - 1; i >= 0; i--)
            if (ent_ok_q[i] && ent_len_q[i] == n_nx && ((ent_code_q[i] ^ acc_nx) & ent_mask_q[i]) == '0) begin
                hit = 1'b1;
                hit_sym = ent_sym_q[i];
            end
    end
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ent_sym_d = ent_sym_q;
        ent_code_d = ent_code_q;
        ent_mask_d = ent_mask_q;
        ent_len_d = ent_len_q;
        ent_ok_d = ent_ok_q;
        acc_d = acc_q;
        n_d = n_q;
        sym_valid_d = 1'b0;
        err_d = 1'b0;
        sym_out_d = sym_out_q;
        if (state_q == LOAD) begin
            if (load_valid) begin
                for (int i = 0; i < NUM_SYMS; i++)
                    if (CNT_W'(i) == count_q) begin
                        ent_sym_d[i] = load_sym;
                        ent_code_d[i] = load_code;
                        ent_mask_d[i] = load_mask;
                        ent_len_d[i] = load_len;
                        ent_ok_d[i] = load_ok;
                    end
                count_d = count_q + 1'b1;
                state_d = (load_last || count_d == CNT_W'(NUM_SYMS)) ? DECODE : LOAD;
            end
        end else if (bit_valid) begin
            sym_valid_d = hit;
            sym_out_d = hit ? hit_sym : sym_out_q;
            err_d = !hit && n_nx == LEN_W'(CODE_W);
            acc_d = (hit || err_d) ? '0 : acc_nx;
            n_d = (hit || err_d) ? '0 : n_nx;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            count_q <= '0;
            ent_sym_q <= '{default: '0};
            ent_code_q <= '{default: '0};
            ent_mask_q <= '{default: '0};
            ent_len_q <= '{default: '0};
            ent_ok_q <= '0;
            acc_q <= '0;
            n_q <= '0;
            sym_valid_q <= 1'b0;
            err_q <= 1'b0;
            sym_out_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ent_sym_q <= ent_sym_d;
            ent_code_q <= ent_code_d;
            ent_mask_q <= ent_mask_d;
            ent_len_q <= ent_len_d;
            ent_ok_q <= ent_ok_d;
            acc_q <= acc_d;
            n_q <= n_d;
            sym_valid_q <= sym_valid_d;
            err_q <= err_d;
            sym_out_q <= sym_out_d;
        end
    end
    assign table_ready = state_q == DECODE;
    assign sym_valid = sym_valid_q;
    assign sym_out = sym_out_q;
    assign err = err_q;
endmodule

// File: tb/tb_huff_decoder.sv
// tb_huff_decoder: directed stimulus with a scoreboard of expected symbol/err pulses and their cycles
module tb_huff_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_valid = 1'b0;
    logic [7:0] load_sym = '0;
    logic [2:0] load_code = '0;
    logic [2:0] load_mask = '0;
    logic load_last = 1'b0;
    logic table_ready;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;
    logic sym_valid;
    logic [7:0] sym_out;
    logic err;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    typedef struct {
        logic is_err;
        logic [7:0] sym;
        int cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_m;

    huff_decoder dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_sym(load_sym), .load_code(load_code),
        .load_mask(load_mask), .load_last(load_last), .table_ready(table_ready),
        .bit_valid(bit_valid), .bit_in(bit_in),
        .sym_valid(sym_valid), .sym_out(sym_out), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sym_valid || err) begin
            check("sym_err_exclusive", {31'b0, sym_valid & err}, 0);
            if (exp_q.size() == 0) check("unexpected_output", {30'b0, sym_valid, err}, 0);
            else begin
                e_m = exp_q.pop_front();
                check("pulse_is_err", {31'b0, err}, {31'b0, e_m.is_err});
                if (!e_m.is_err) check("sym_out", {24'b0, sym_out}, {24'b0, e_m.sym});
                check("pulse_cycle", cyc, e_m.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid = 1'b0;
            load_valid = 1'b0;
            load_last = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        load_valid = 1'b0;
        load_last = 1'b0;
        bit_valid = 1'b1;
        bit_in = b;
    endtask

    task automatic load(input logic [7:0] s, input logic [2:0] c, input logic [2:0] m, input logic last);
        @(negedge clk);
        bit_valid = 1'b0;
        load_valid = 1'b1;
        load_sym = s;
        load_code = c;
        load_mask = m;
        load_last = last;
    endtask

    task automatic expect_sym(input logic [7:0] s);
        exp_q.push_back('{1'b0, s, cyc + 1});
    endtask

    task automatic expect_err();
        exp_q.push_back('{1'b1, 8'h00, cyc + 1});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bit_valid = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("rst_table_ready", {31'b0, table_ready}, 0);
        check("rst_sym_valid", {31'b0, sym_valid}, 0);
        check("rst_sym_out", {24'b0, sym_out}, 0);
        check("rst_err", {31'b0, err}, 0);
    endtask

    task automatic load_std();
        load(8'h41, 3'b000, 3'b001, 1'b0);
        load(8'h42, 3'b010, 3'b011, 1'b0);
        load(8'h43, 3'b110, 3'b111, 1'b0);
        load(8'h44, 3'b111, 3'b111, 1'b1);
        check("ready_before_last", {31'b0, table_ready}, 0);
        idle(1);
        check("ready_after_last", {31'b0, table_ready}, 1);
    endtask

    task automatic drain(input string tag);
        idle(3);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        idle(2);
        do_reset();
        // four-entry codebook, continuous stream, then back-to-back 1-bit codes
        load_std();
        send_bit(0); expect_sym(8'h41);
        send_bit(1); send_bit(0); expect_sym(8'h42);
        send_bit(1); send_bit(1); send_bit(0); expect_sym(8'h43);
        send_bit(1); send_bit(1); send_bit(1); expect_sym(8'h44);
        send_bit(0); expect_sym(8'h41);
        send_bit(0); expect_sym(8'h41);
        drain("t1_missing_outputs");
        check("sym_out_holds", {24'b0, sym_out}, 32'h41);
        // gaps between bits of one code
        send_bit(1); idle(3);
        send_bit(1); idle(1);
        send_bit(0); expect_sym(8'h43);
        drain("t3_missing_outputs");
        // reset mid-code, bits ignored in LOAD, reload
        send_bit(1); send_bit(1);
        do_reset();
        send_bit(0); send_bit(0);
        drain("t4_load_ignores_bits");
        load_std();
        send_bit(0); expect_sym(8'h41);
        drain("t4_missing_outputs");
        // two-entry codebook, err then symbol
        do_reset();
        load(8'h41, 3'b000, 3'b001, 1'b0);
        load(8'h42, 3'b010, 3'b011, 1'b1);
        check("t2_ready_before", {31'b0, table_ready}, 0);
        idle(1);
        check("t2_ready_after", {31'b0, table_ready}, 1);
        send_bit(1); send_bit(1); send_bit(1); expect_err();
        send_bit(0); expect_sym(8'h41);
        drain("t2_missing_outputs");
        // duplicate codes: lowest index wins
        do_reset();
        load(8'h10, 3'b000, 3'b001, 1'b0);
        load(8'h20, 3'b000, 3'b001, 1'b1);
        send_bit(0); expect_sym(8'h10);
        drain("t6_missing_outputs");
        // overfull load: entries past NUM_SYMS dropped, invalid mask never matches
        do_reset();
        send_bit(0); send_bit(1);
        load(8'h41, 3'b010, 3'b011, 1'b0);
        load(8'h42, 3'b110, 3'b111, 1'b0);
        load(8'h43, 3'b111, 3'b111, 1'b0);
        load(8'h44, 3'b000, 3'b010, 1'b0);
        check("t5_ready_before_4th", {31'b0, table_ready}, 0);
        load(8'h55, 3'b000, 3'b001, 1'b0);
        check("t5_ready_after_4th", {31'b0, table_ready}, 1);
        load(8'h66, 3'b001, 3'b001, 1'b0);
        idle(1);
        send_bit(0); send_bit(1); send_bit(0); expect_err();
        send_bit(1); send_bit(0); expect_sym(8'h41);
        drain("t5_missing_outputs");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
